// File: rtl/fft_mdc_stage.sv
// Radix-2 multi-path delay commutator FFT stage: commutator, two delay lines,
// butterfly, twiddle multiply on the lower branch, registered outputs.
module fft_mdc_stage #(
  parameter int WIDTH    = 9,
  parameter int DEPTH    = 4,
  parameter int TW_WIDTH = 9,
  parameter int SCALE    = 0,
  localparam int LOG2D   = $clog2(DEPTH),
  localparam int AW      = (LOG2D > 0) ? LOG2D : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sync,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     in_up_re,
  input  logic signed [WIDTH-1:0]     in_up_im,
  input  logic signed [WIDTH-1:0]     in_l_re,
  input  logic signed [WIDTH-1:0]     in_l_im,
  output logic        [AW-1:0]        tw_addr,
  input  logic signed [TW_WIDTH-1:0]  tw_re,
  input  logic signed [TW_WIDTH-1:0]  tw_im,
  output logic                        out_valid,
  output logic signed [WIDTH-1:0]     out_up_re,
  output logic signed [WIDTH-1:0]     out_up_im,
  output logic signed [WIDTH-1:0]     out_l_re,
  output logic signed [WIDTH-1:0]     out_l_im
);

  localparam int CW  = LOG2D + 1;
  localparam int PRW = $clog2(DEPTH + 1);
  localparam int PW  = WIDTH + TW_WIDTH + 3;
  localparam logic [PRW-1:0]       PRIME_FULL = PRW'(DEPTH);
  localparam logic signed [PW-1:0] ONE        = PW'(1);
  localparam logic signed [PW-1:0] RND        = ONE <<< (TW_WIDTH - 3);
  localparam logic signed [PW-1:0] SAT_MAX    = (ONE <<< (WIDTH - 1)) - ONE;
  localparam logic signed [PW-1:0] SAT_MIN    = -(ONE <<< (WIDTH - 1));

  typedef logic [2*WIDTH-1:0] cplx_t;

  cplx_t                   line_l_q [DEPTH];
  cplx_t                   line_l_d [DEPTH];
  cplx_t                   line_u_q [DEPTH];
  cplx_t                   line_u_d [DEPTH];
  logic [CW-1:0]           cnt_q, cnt_d, cnt_eff;
  logic [PRW-1:0]          prime_q, prime_d, prime_eff;
  logic                    restart, sel, primed;
  logic signed [WIDTH-1:0] dl_re, dl_im, du_re, du_im;
  logic signed [WIDTH-1:0] cu_re, cu_im, cl_re, cl_im;
  logic signed [PW-1:0]    a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [PW-1:0]    p_re_full, p_im_full, p_re, p_im;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] out_up_re_q, out_up_re_d, out_up_im_q, out_up_im_d;
  logic signed [WIDTH-1:0] out_l_re_q, out_l_re_d, out_l_im_q, out_l_im_d;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WIDTH-1:0];
    else                  sat = v[WIDTH-1:0];
  endfunction

  generate
    if (LOG2D == 0) begin : g_addr_d1
      assign tw_addr = '0;
    end else begin : g_addr
      assign tw_addr = cnt_eff[AW-1:0];
    end
  endgenerate

  always_comb begin
    // A sync sample is processed as the first sample of a fresh frame.
    restart   = sync & in_valid;
    cnt_eff   = restart ? '0 : cnt_q;
    prime_eff = restart ? '0 : prime_q;
    primed    = (prime_eff >= PRIME_FULL);
    sel       = cnt_eff[LOG2D];

    {dl_re, dl_im} = line_l_q[DEPTH-1];
    {du_re, du_im} = line_u_q[DEPTH-1];
    if (sel) begin
      cu_re = dl_re;    cu_im = dl_im;
      cl_re = in_up_re; cl_im = in_up_im;
    end else begin
      cu_re = in_up_re; cu_im = in_up_im;
      cl_re = dl_re;    cl_im = dl_im;
    end

    a_re = PW'(du_re) + PW'(cl_re);
    a_im = PW'(du_im) + PW'(cl_im);
    b_re = PW'(du_re) - PW'(cl_re);
    b_im = PW'(du_im) - PW'(cl_im);
    if (SCALE != 0) begin
      a_re = (a_re + ONE) >>> 1;
      a_im = (a_im + ONE) >>> 1;
      b_re = (b_re + ONE) >>> 1;
      b_im = (b_im + ONE) >>> 1;
    end

    t_re      = PW'(tw_re);
    t_im      = PW'(tw_im);
    p_re_full = b_re * t_re - b_im * t_im + RND;
    p_im_full = b_re * t_im + b_im * t_re + RND;
    p_re      = p_re_full >>> (TW_WIDTH - 2);
    p_im      = p_im_full >>> (TW_WIDTH - 2);

    cnt_d       = cnt_q;
    prime_d     = prime_q;
    line_l_d    = line_l_q;
    line_u_d    = line_u_q;
    out_valid_d = 1'b0;
    out_up_re_d = out_up_re_q;
    out_up_im_d = out_up_im_q;
    out_l_re_d  = out_l_re_q;
    out_l_im_d  = out_l_im_q;

    if (in_valid) begin
      cnt_d       = cnt_eff + CW'(1);
      prime_d     = primed ? PRIME_FULL : prime_eff + PRW'(1);
      line_l_d[0] = {in_l_re, in_l_im};
      line_u_d[0] = {cu_re, cu_im};
      for (int i = 1; i < DEPTH; i++) begin
        line_l_d[i] = line_l_q[i-1];
        line_u_d[i] = line_u_q[i-1];
      end
      out_valid_d = primed;
      out_up_re_d = sat(a_re);
      out_up_im_d = sat(a_im);
      out_l_re_d  = sat(p_re);
      out_l_im_d  = sat(p_im);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      prime_q     <= '0;
      out_valid_q <= 1'b0;
      out_up_re_q <= '0;
      out_up_im_q <= '0;
      out_l_re_q  <= '0;
      out_l_im_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        line_l_q[i] <= '0;
        line_u_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      prime_q     <= prime_d;
      out_valid_q <= out_valid_d;
      out_up_re_q <= out_up_re_d;
      out_up_im_q <= out_up_im_d;
      out_l_re_q  <= out_l_re_d;
      out_l_im_q  <= out_l_im_d;
      for (int i = 0; i < DEPTH; i++) begin
        line_l_q[i] <= line_l_d[i];
        line_u_q[i] <= line_u_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_up_re = out_up_re_q;
  assign out_up_im = out_up_im_q;
  assign out_l_re  = out_l_re_q;
  assign out_l_im  = out_l_im_q;

endmodule

// File: tb/tb_fft_mdc_stage.sv
// Directed bench for fft_mdc_stage: an unscaled and a scaled instance share the
// data/twiddle inputs; each has its own in_valid.
module tb_fft_mdc_stage;

  localparam int W  = 9;
  localparam int TW = 9;

  typedef struct {
    logic sy;
    int   up_re, up_im, l_re, l_im, tw_re, tw_im;
    int   e_addr;
    logic e_vld;
    int   e_up_re, e_up_im, e_l_re, e_l_im;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, sync, vld_m, vld_s;
  logic signed [W-1:0]  in_up_re, in_up_im, in_l_re, in_l_im;
  logic signed [TW-1:0] tw_re, tw_im;
  logic [1:0]           ta_m, ta_s;
  logic                 ov_m, ov_s;
  logic signed [W-1:0]  our_m, oui_m, olr_m, oli_m;
  logic signed [W-1:0]  our_s, oui_s, olr_s, oli_s;

  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  fft_mdc_stage #(.WIDTH(W), .DEPTH(4), .TW_WIDTH(TW), .SCALE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(vld_m),
    .in_up_re(in_up_re), .in_up_im(in_up_im), .in_l_re(in_l_re), .in_l_im(in_l_im),
    .tw_addr(ta_m), .tw_re(tw_re), .tw_im(tw_im), .out_valid(ov_m),
    .out_up_re(our_m), .out_up_im(oui_m), .out_l_re(olr_m), .out_l_im(oli_m)
  );

  fft_mdc_stage #(.WIDTH(W), .DEPTH(4), .TW_WIDTH(TW), .SCALE(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(vld_s),
    .in_up_re(in_up_re), .in_up_im(in_up_im), .in_l_re(in_l_re), .in_l_im(in_l_im),
    .tw_addr(ta_s), .tw_re(tw_re), .tw_im(tw_im), .out_valid(ov_s),
    .out_up_re(our_s), .out_up_im(oui_s), .out_l_re(olr_s), .out_l_im(oli_s)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic add(input logic sy, input int ur, input int ui, input int lr, input int li,
                     input int tr, input int ti, input int addr, input logic vld,
                     input int eur, input int eui, input int elr, input int eli);
    vec_t v;
    v.sy = sy; v.up_re = ur; v.up_im = ui; v.l_re = lr; v.l_im = li;
    v.tw_re = tr; v.tw_im = ti; v.e_addr = addr; v.e_vld = vld;
    v.e_up_re = eur; v.e_up_im = eui; v.e_l_re = elr; v.e_l_im = eli;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input bit scaled, input string tag, input int idx);
    @(negedge clk);
    in_up_re = W'(v.up_re);  in_up_im = W'(v.up_im);
    in_l_re  = W'(v.l_re);   in_l_im  = W'(v.l_im);
    tw_re    = TW'(v.tw_re); tw_im    = TW'(v.tw_im);
    sync     = v.sy;
    vld_m    = !scaled;
    vld_s    = scaled;
    #1 chk({tag, " tw_addr"}, scaled ? int'(ta_s) : int'(ta_m), v.e_addr);
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, scaled ? int'(ov_s) : int'(ov_m), int'(v.e_vld));
    chk({tag, " out_up_re"}, scaled ? int'(our_s) : int'(our_m), v.e_up_re);
    chk({tag, " out_up_im"}, scaled ? int'(oui_s) : int'(oui_m), v.e_up_im);
    chk({tag, " out_l_re"},  scaled ? int'(olr_s) : int'(olr_m), v.e_l_re);
    chk({tag, " out_l_im"},  scaled ? int'(oli_s) : int'(oli_m), v.e_l_im);
    $display("%s #%0d up=(%0d,%0d) l=(%0d,%0d) sync=%0b -> vld=%0b up=(%0d,%0d) l=(%0d,%0d)",
             tag, idx, v.up_re, v.up_im, v.l_re, v.l_im, v.sy, v.e_vld,
             v.e_up_re, v.e_up_im, v.e_l_re, v.e_l_im);
  endtask

  task automatic idle_chk(input int exp_addr, input int exp_up);
    @(negedge clk);
    vld_m = 1'b0; vld_s = 1'b0; sync = 1'b0;
    #1 chk("gap tw_addr", int'(ta_m), exp_addr);
    @(posedge clk);
    #1;
    chk("gap out_valid", int'(ov_m), 0);
    chk("gap out_up_re", int'(our_m), exp_up);
    $display("gap addr=%0d hold up_re=%0d", exp_addr, exp_up);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sync = 1'b0; vld_m = 1'b0; vld_s = 1'b0;
    in_up_re = '0; in_up_im = '0; in_l_re = '0; in_l_im = '0;
    tw_re = '0; tw_im = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(ov_m), 0);
    chk("reset out_up_re", int'(our_m), 0);
    chk("reset tw_addr", int'(ta_m), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unscaled stream: ramp frame, positive/negative saturation, complex twiddle, lower-line path.
    for (int i = 0; i < 36; i++) begin
      if (i < 8)
        add(0, 10*(i+1), 0, 0, 0, 127, 0, i%4, i >= 4,
            (i >= 4) ? 60 + 20*(i-4) : 0, 0, (i >= 4) ? -40 : 0, 0);
      else if (i < 16)
        add(0, 255, 0, 0, 0, 127, 0, i%4, 1, (i >= 12) ? 255 : 0, 0, 0, 0);
      else if (i < 24)
        add(0, -256, 0, 0, 0, 127, 0, i%4, 1, (i >= 20) ? -256 : 0, 0, 0, 0);
      else if (i < 28)
        add(0, 20, 10, 6, -4, 64, 64, i%4, 1, 0, 0, 0, 0);
      else if (i < 32)
        add(0, 0, 0, 0, 0, 64, 64, i%4, 1, 20, 10, 5, 15);
      else
        add(0, 0, 0, 0, 0, 127, 0, i%4, 1, 6, -4, 6, -4);
    end
    foreach (vecs[i]) apply(vecs[i], 0, "main", i);

    // Reset asserted mid-stream while in_valid is high.
    @(negedge clk);
    in_up_re = W'(7); vld_m = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", int'(ov_m), 0);
    chk("midrst out_up_re", int'(our_m), 0);
    chk("midrst out_up_im", int'(oui_m), 0);
    chk("midrst out_l_re", int'(olr_m), 0);
    chk("midrst out_l_im", int'(oli_m), 0);
    $display("midrst applied");
    @(negedge clk);
    rst_n = 1'b1; vld_m = 1'b0;
    #1 chk("midrst tw_addr", int'(ta_m), 0);

    // Ramp frame replayed with idle gaps: same results, state frozen in gaps.
    for (int i = 0; i < 8; i++) begin
      int gaps;
      apply(vecs[i], 0, "thr", i);
      gaps = 1 + $urandom_range(0, 1);
      for (int g = 0; g < gaps; g++) idle_chk((i+1)%4, vecs[i].e_up_re);
    end

    // Frame restart on the sixth sample; delay lines hold zeros so data stays 0.
    vecs.delete();
    for (int i = 0; i < 11; i++) begin
      if (i < 5)       add(0, 0, 0, 0, 0, 127, 0, i%4, 1, 0, 0, 0, 0);
      else if (i == 5) add(1, 0, 0, 0, 0, 127, 0, 0, 0, 0, 0, 0, 0);
      else             add(0, 0, 0, 0, 0, 127, 0, (i-5)%4, i >= 9, 0, 0, 0, 0);
    end
    foreach (vecs[i]) apply(vecs[i], 0, "sync", i);

    // Scaled instance: round-half-up on a and b, then twiddle rounding.
    vecs.delete();
    add(0,   3, 0, 0, 0, 0, 127, 0, 0,  0, 0, 0,  0);
    add(0, 128, 0, 0, 0, 0, 127, 1, 0,  0, 0, 0,  0);
    add(0,  -3, 0, 0, 0, 0, 127, 2, 0,  0, 0, 0,  0);
    add(0,   0, 0, 0, 0, 0, 127, 3, 0,  0, 0, 0,  0);
    add(0,   0, 0, 0, 0, 0, 127, 0, 1,  2, 0, 0,  2);
    add(0,   0, 0, 0, 0, 0, 127, 1, 1, 64, 0, 0, 64);
    add(0,   0, 0, 0, 0, 0, 127, 2, 1, -1, 0, 0, -1);
    add(0,   0, 0, 0, 0, 0, 127, 3, 1,  0, 0, 0,  0);
    foreach (vecs[i]) apply(vecs[i], 1, "scale", i);

    @(negedge clk);
    vld_m = 1'b0; vld_s = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
